rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter_pkg.sv | 20 ++
 rtl/rf_wb_arbiter_rr_arb2.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 97 +++++++++
 tb/tb_rf_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: widths,
// requester indices and the write-request record.
package rf_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int ADDR_DEPTH = 32;

   // Requester index; also the bit position of each requester in grant vectors.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_idx_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the ALU, bit 1 the LSU.
// The priority pointer only rotates after a contended grant, so a lone
// requester never disturbs fairness between the two.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   req_idx_t ptr;

   // One-hot grant: a single valid wins outright, contention goes to the pointer.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (valid == 2'b11)
            grant = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
         else
            grant = valid;
      end
   end

   // Hand priority to the loser after every contended grant.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= REQ_ALU;
      else if (valid == 2'b11)
         ptr <= (ptr == REQ_ALU) ? REQ_LSU : REQ_ALU;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back controller for the 32-entry register file: arbitrates the
// single write port between ALU and LSU and tracks pending writes so decode
// can stall on RAW hazards.
// Optional feature: define RF_WB_BYPASS_EN to expose byp_valid/byp_addr/
// byp_data, a copy of the registered write port for decode forwarding.
module rf_wb_arbiter
   import rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  WE3,
   output logic [ADDR_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0] WD3,
   output logic [ADDR_DEPTH-1:0] sb_busy
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                  byp_valid,
   output logic [ADDR_WIDTH-1:0] byp_addr,
   output logic [DATA_WIDTH-1:0] byp_data
`endif
);

   logic [1:0]            grant;
   logic                  vld_p0;
   wr_req_t               req_p0;
   logic [ADDR_DEPTH-1:0] sb_next;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .valid ({lsu_valid, alu_valid}),
      .grant (grant)
   );

   assign alu_ready = grant[0];
   assign lsu_ready = grant[1];
   assign vld_p0    = |grant;

   // Select the granted request; grant is one-hot so LSU overrides the default.
   always_comb begin
      req_p0 = '{addr: alu_addr, data: alu_data};
      if (grant[1])
         req_p0 = '{addr: lsu_addr, data: lsu_data};
   end

   // ---- stage p0 -> p1: registered register-file write port ----
   // Writes to x0 are accepted but never enabled; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         WE3 <= 1'b0;
         A3  <= '0;
         WD3 <= '0;
      end else if (vld_p0) begin
         WE3 <= (req_p0.addr != '0);
         A3  <= req_p0.addr;
         WD3 <= req_p0.data;
      end else begin
         WE3 <= 1'b0;
      end
   end

   // Next scoreboard: retire the written register, then apply the issue so a
   // same-address issue (younger) wins; x0 is never pending.
   always_comb begin
      sb_next = sb_busy;
      if (vld_p0)
         sb_next[req_p0.addr] = 1'b0;
      if (iss_valid)
         sb_next[iss_rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   // Pending-write flags, cleared in step with WE3.
   always_ff @(posedge clk) begin
      if (rst)
         sb_busy <= '0;
      else
         sb_busy <= sb_next;
   end

`ifdef RF_WB_BYPASS_EN
   assign byp_valid = WE3;
   assign byp_addr  = A3;
   assign byp_data  = WD3;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: table of per-cycle requests with hand-derived
// grants, a queue of expected write-port/scoreboard values, plus reset
// sequences at start and mid-stream.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, lsu_valid, iss_valid;
   logic [4:0]  alu_addr, lsu_addr, iss_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready;
   logic        WE3;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic [31:0] sb_busy;
`ifdef RF_WB_BYPASS_EN
   logic        byp_valid;
   logic [4:0]  byp_addr;
   logic [31:0] byp_data;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_addr  (lsu_addr),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .WE3       (WE3),
      .A3        (A3),
      .WD3       (WD3),
      .sb_busy   (sb_busy)
`ifdef RF_WB_BYPASS_EN
      ,
      .byp_valid (byp_valid),
      .byp_addr  (byp_addr),
      .byp_data  (byp_data)
`endif
   );

   typedef struct {
      logic        alu_v;
      logic [4:0]  alu_a;
      logic [31:0] alu_d;
      logic        lsu_v;
      logic [4:0]  lsu_a;
      logic [31:0] lsu_d;
      logic        iss_v;
      logic [4:0]  iss_r;
      logic        exp_alu_rdy;
      logic        exp_lsu_rdy;
   } vec_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] sb;
   } exp_t;

   exp_t        expq[$];
   logic [4:0]  m_a;
   logic [31:0] m_d;
   logic [31:0] m_sb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive, check readies, predict, then compare after the edge.
   task automatic cycle(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      alu_valid = v.alu_v; alu_addr = v.alu_a; alu_data = v.alu_d;
      lsu_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_data = v.lsu_d;
      iss_valid = v.iss_v; iss_rd = v.iss_r;
      #1;
      chk($sformatf("alu_ready[%0d]", idx), {31'd0, alu_ready}, {31'd0, v.exp_alu_rdy});
      chk($sformatf("lsu_ready[%0d]", idx), {31'd0, lsu_ready}, {31'd0, v.exp_lsu_rdy});
      e.we = 1'b0; e.a = m_a; e.d = m_d; e.sb = m_sb;
      if (v.exp_alu_rdy) begin
         e.we = (v.alu_a != 5'd0); e.a = v.alu_a; e.d = v.alu_d; e.sb[v.alu_a] = 1'b0;
      end else if (v.exp_lsu_rdy) begin
         e.we = (v.lsu_a != 5'd0); e.a = v.lsu_a; e.d = v.lsu_d; e.sb[v.lsu_a] = 1'b0;
      end
      if (v.iss_v) e.sb[v.iss_r] = 1'b1;
      e.sb[0] = 1'b0;
      m_a = e.a; m_d = e.d; m_sb = e.sb;
      expq.push_back(e);
      @(posedge clk);
      #1;
      e = expq.pop_front();
      chk($sformatf("WE3[%0d]", idx), {31'd0, WE3}, {31'd0, e.we});
      chk($sformatf("A3[%0d]", idx), {27'd0, A3}, {27'd0, e.a});
      chk($sformatf("WD3[%0d]", idx), WD3, e.d);
      chk($sformatf("sb_busy[%0d]", idx), sb_busy, e.sb);
`ifdef RF_WB_BYPASS_EN
      chk($sformatf("byp_valid[%0d]", idx), {31'd0, byp_valid}, {31'd0, e.we});
      chk($sformatf("byp_addr[%0d]", idx), {27'd0, byp_addr}, {27'd0, e.a});
      chk($sformatf("byp_data[%0d]", idx), byp_data, e.d);
`endif
   endtask

   task automatic reset_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1;
         alu_valid = 1'b1; lsu_valid = 1'b1; iss_valid = 1'b0;
         #1;
         chk({tag, "_alu_ready"}, {31'd0, alu_ready}, 32'd0);
         chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd0);
         @(posedge clk);
         #1;
         chk({tag, "_WE3"}, {31'd0, WE3}, 32'd0);
         chk({tag, "_A3"}, {27'd0, A3}, 32'd0);
         chk({tag, "_WD3"}, WD3, 32'd0);
         chk({tag, "_sb_busy"}, sb_busy, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      alu_valid = 1'b0; lsu_valid = 1'b0;
      m_a = 5'd0; m_d = 32'd0; m_sb = 32'd0;
   endtask

   vec_t vecs[20];
   vec_t v_hs, v_after;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          alu_v alu_a  alu_d         lsu_v lsu_a  lsu_d         iss  rd    ar    lr
      vecs[0]  = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd4,  32'h00000044, 1'b0, 5'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 5'd3,  32'h00000035, 1'b1, 5'd4,  32'h00000044, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 5'd1,  32'h00000011, 1'b1, 5'd2,  32'h00000022, 1'b0, 5'd0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd1,  32'h00000111, 1'b1, 5'd2,  32'h00000022, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 5'd1,  32'h00000111, 1'b1, 5'd2,  32'h00000222, 1'b0, 5'd0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 5'd1,  32'h00001111, 1'b1, 5'd2,  32'h00000222, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 5'd7,  32'h77777777, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 5'd7,  32'h70707070, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h88888888, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 5'd9,  32'h99999999, 1'b1, 5'd10, 32'hAAAAAAAA, 1'b0, 5'd0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hAAAAAAAA, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33333333, 1'b0, 5'd0, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b0};

      rst = 1'b1;
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
      lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h2;
      iss_valid = 1'b0; iss_rd = 5'd0;
      m_a = 5'd0; m_d = 32'd0; m_sb = 32'd0;

      reset_cycles(2, "reset");

      for (int i = 0; i < 20; i++)
         cycle(vecs[i], i);

      // Hand checks on the scoreboard corner cases above.
      chk("sb7_set_wins", {31'd0, sb_busy[7]}, 32'd1);
      chk("sb3_cleared", {31'd0, sb_busy[3]}, 32'd0);

      // Handshake plus an issue, then reset the very next cycle.
      v_hs = '{1'b1, 5'd4, 32'h0000ABCD, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0};
      cycle(v_hs, 100);
      chk("mid_sb9_set", {31'd0, sb_busy[9]}, 32'd1);
      reset_cycles(1, "midrst");

      // Pointer must be back on the ALU after reset.
      v_after = '{1'b1, 5'd12, 32'h12121212, 1'b1, 5'd13, 32'h13131313, 1'b0, 5'd0, 1'b1, 1'b0};
      cycle(v_after, 101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
